// File: rtl/sodor_gen_pkg.sv
// Shared types and constants for the random RISC-V instruction stream generator.
package sodor_gen_pkg;

    localparam int unsigned LFSR_W   = 64;
    localparam int unsigned FIELD_W  = 36;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned HIST_MAX = 4;

    localparam logic [6:0]         OP_IMM    = 7'b0010011;
    localparam logic [6:0]         OP        = 7'b0110011;
    localparam logic [INSTR_W-1:0] NOP       = 32'h00000013;
    localparam logic [LFSR_W-1:0]  LFSR_TAPS = 64'hD800000000000000;

    typedef enum logic [1:0] {
        MODE_ITYPE = 2'd0,
        MODE_RTYPE = 2'd1,
        MODE_MIXED = 2'd2,
        MODE_NOP   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Low 36 bits of the LFSR state viewed as instruction fields (MSB first).
    typedef struct packed {
        logic [1:0]       hidx;
        logic [1:0]       hz;
        logic             typ;
        logic             f7b;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [2:0]       funct3;
        logic [REG_W-1:0] rs1;
        logic [11:0]      imm;
    } fields_t;

    typedef logic [HIST_MAX-1:0][REG_W-1:0] hist_t;

    // One Galois step of the 64-bit LFSR.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] r);
        return (r >> 1) ^ (r[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/sodor_lfsr64.sv
// 64-bit Galois LFSR that advances once per step request.
module sodor_lfsr64
    import sodor_gen_pkg::*;
#(
    parameter logic [63:0] SEED = 64'd528
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    // An all-zero state would lock up, so a zero seed starts from 1.
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 64'd0) ? 64'd1 : SEED;

    // State register: reload the seed on reset, advance on step.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= SEED_EFF;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/sodor_instr_gen.sv
// Random I/R-type instruction stream source with valid/ready output,
// bounded run length and RAW-hazard injection from recent rd values.
module sodor_instr_gen
    import sodor_gen_pkg::*;
#(
    parameter logic [63:0] SEED       = 64'd528,
    parameter int unsigned HIST_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic               hazard_en,
    input  logic [CNT_W-1:0]   num_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   count,
    output logic               done
);

    localparam logic [1:0] HIDX_MASK = 2'(HIST_DEPTH - 1);

    state_e             state_q, state_d;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [LFSR_W-1:0]  lfsr_src;
    hist_t              hist_q, hist_d;
    logic [CNT_W-1:0]   num_q, num_d, count_d, count_inc;
    logic               valid_d, done_d;
    logic [INSTR_W-1:0] instr_d, word;
    logic               accept;
    fields_t            fld;
    mode_e              mode_sel;
    logic               rtype;
    logic [REG_W-1:0]   rs1_sel;
    logic [11:0]        imm_sel;
    logic [6:0]         funct7;
    logic               unused_lfsr_hi;

    assign accept    = out_valid & out_ready;
    assign count_inc = count + CNT_W'(1);

    sodor_lfsr64 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .step    (accept),
        .state   (lfsr_q)
    );

    // History update: push the accepted rd (if nonzero); slots past HIST_DEPTH stay zero.
    always_comb begin
        hist_d = hist_q;
        if (accept && (out_instr[11:7] != '0)) begin
            hist_d[0] = out_instr[11:7];
            for (int unsigned i = 1; i < HIST_MAX; i++) begin
                hist_d[i] = (i < HIST_DEPTH) ? hist_q[i-1] : '0;
            end
        end
    end

    // Encoder: next word from the post-accept LFSR state and history.
    always_comb begin
        lfsr_src       = accept ? lfsr_next(lfsr_q) : lfsr_q;
        fld            = fields_t'(lfsr_src[FIELD_W-1:0]);
        unused_lfsr_hi = ^lfsr_src[LFSR_W-1:FIELD_W];
        mode_sel       = mode_e'(mode);

        rs1_sel = fld.rs1;
        if (hazard_en && (fld.hz == 2'b11)) begin
            rs1_sel = hist_d[fld.hidx & HIDX_MASK];
        end

        imm_sel = fld.imm;
        if (fld.funct3 == 3'd1) begin
            imm_sel = fld.imm & 12'h01F;
        end else if (fld.funct3 == 3'd5) begin
            imm_sel = fld.imm & 12'h41F;
        end

        funct7 = 7'b0;
        if ((fld.funct3 == 3'd0) || (fld.funct3 == 3'd5)) begin
            funct7 = {1'b0, fld.f7b, 5'b0};
        end

        rtype = (mode_sel == MODE_RTYPE) || ((mode_sel == MODE_MIXED) && fld.typ);

        if (mode_sel == MODE_NOP) begin
            word = NOP;
        end else if (rtype) begin
            word = {funct7, fld.rs2, rs1_sel, fld.funct3, fld.rd, OP};
        end else begin
            word = {imm_sel, rs1_sel, fld.funct3, fld.rd, OP_IMM};
        end
    end

    // Run control: next state and next values of all output registers.
    always_comb begin
        state_d = state_q;
        valid_d = out_valid;
        instr_d = out_instr;
        count_d = count;
        done_d  = done;
        num_d   = num_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                    instr_d = word;
                    count_d = '0;
                    done_d  = 1'b0;
                    num_d   = num_instr;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    count_d = count_inc;
                    if ((num_q != '0) && (count_inc == num_q)) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        instr_d = NOP;
                        done_d  = 1'b1;
                    end else begin
                        instr_d = word;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                instr_d = NOP;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            out_valid <= 1'b0;
            out_instr <= NOP;
            count     <= '0;
            done      <= 1'b0;
            num_q     <= '0;
            hist_q    <= '0;
        end else begin
            state_q   <= state_d;
            out_valid <= valid_d;
            out_instr <= instr_d;
            count     <= count_d;
            done      <= done_d;
            num_q     <= num_d;
            hist_q    <= hist_d;
        end
    end

endmodule

// File: doc/sodor_instr_gen.md
# sodor_instr_gen

Synthesizable, parametrised random RISC-V instruction stream generator for the sodor5 verification harness. It drives the core's imem response data in place of ad-hoc per-test `$urandom` stimulus. The block adds:
- selectable I-type / R-type / mixed / NOP modes;
- a valid/ready handshake;
- a bounded instruction count;
- controllable RAW-hazard injection from a history of recent destination registers.

It sits between the test controller and the imem response port of `sodor5_verif`.

## Interface
Parameters:
- `SEED`, 64'd528: initial LFSR state. A value of 0 is replaced by 64'd1.
- `HIST_DEPTH`, 4: number of recent nonzero rd values kept for hazard injection. Legal values are 1, 2, 4.
- `CNT_W`, 16: width of the instruction count and limit.

Ports:
- `clk`, in, 1: clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: begins a run; pulse.
- `mode`, in, 2: 0 = I-type ALU, 1 = R-type ALU, 2 = mixed, 3 = NOP only.
- `hazard_en`, in, 1: enables rs1 substitution from the rd history.
- `num_instr`, in, CNT_W: run length. 0 means unlimited.
- `out_valid`, out, 1: `out_instr` is valid.
- `out_ready`, in, 1: consumer accepts the instruction.
- `out_instr`, out, 32: instruction word.
- `count`, out, CNT_W: instructions accepted in the current run.
- `done`, out, 1: high while in DONE.

## Operation
- **FSM states:** IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE on the accept where `count+1 == num_instr` (only when `num_instr` is nonzero).
  - DONE → RUN on `start`. This clears `count`; the LFSR and history continue from their current values.
  - `start` in RUN is ignored.
- **LFSR:** 64-bit Galois, `next = (r>>1) ^ (r[0] ? 64'hD800000000000000 : 0)`. It steps once per accept.
- **Field extraction** from the current LFSR state `r`:
  - imm = r[11:0], rs1 = r[16:12], funct3 = r[19:17], rd = r[24:20], rs2 = r[29:25].
  - f7b = r[30], type = r[31] (mixed mode only; 1 selects R-type).
  - hazard fires when r[33:32] == 2'b11; history index hidx = r[35:34] & (HIST_DEPTH-1).
- **I-type encoding:** {imm, rs1, funct3, rd, 7'b0010011}.
  - funct3 = 1: imm &= 12'h01F.
  - funct3 = 5: imm &= 12'h41F.
- **R-type encoding:** {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
  - funct7 = {1'b0, f7b, 5'b0} when funct3 ∈ {0, 5}; otherwise 7'b0.
- **NOP mode and non-RUN states:** the instruction is 32'h00000013.
- **Hazard injection:** when `hazard_en` is high and the hazard condition fires, rs1 is replaced by `hist[hidx]`.
- **History:** a shift register, reset to all zeros. It pushes the rd of each accepted instruction only if that rd is nonzero. `hist[0]` is the newest entry.
- **Sampling:** `mode` and `hazard_en` are sampled whenever the output register loads, so a change takes effect on the next loaded instruction.

## Timing
- **Reset values:** `out_valid` = 0, `out_instr` = 32'h00000013, `count` = 0, `done` = 0, state = IDLE, LFSR = SEED (or 1 if SEED is 0), history = 0. Reset overrides everything, including mid-run and mid-handshake.
- **Start latency:** `start` sampled at edge t gives `out_valid` = 1 with the first instruction after edge t. That instruction comes from the current LFSR state with no step.
- **Accept:** an accept (`out_valid & out_ready`) at edge t does all of the following at that edge:
  - steps the LFSR;
  - increments `count`;
  - updates the history;
  - loads the next instruction, computed from the stepped LFSR and the updated history.
- **Throughput:** one instruction per cycle under continuous `out_ready`.
- **Stall:** while `out_valid` is high and `out_ready` is low, `out_instr` is held stable.
- **Final accept:** when the final instruction is accepted, `out_valid` drops and `done` rises after the same edge, and `out_instr` returns to NOP.
- **Count width:** in unlimited mode `count` wraps from 2^CNT_W-1 to 0 and the run continues.
- **num_instr:** `num_instr` is sampled only on the `start` edge.

## Structure
- **Shared package `sodor_gen_pkg`:**
  - opcodes OP_IMM = 7'b0010011 and OP = 7'b0110011;
  - NOP = 32'h00000013;
  - the LFSR tap constant;
  - the mode enum;
  - the FSM state enum.
- **Sub-module `sodor_lfsr64`:** parameter SEED; inputs clk, reset_n, step; output state. The FSM, field encoder and history stay in the top module.

## Test plan
1. **Reset:** hold `reset_n` = 0 for 3 cycles with `start` = 1 → `out_valid` = 0, `out_instr` = 32'h00000013 and `count` = 0 throughout.
2. **Bounded I-type run:**
   - Stimulus: `mode` = 0, `num_instr` = 5, `start` pulse, `out_ready` = 1.
   - Required: exactly 5 accepts in 5 consecutive cycles, then `done` = 1 and `count` = 5.
   - Every word has opcode 7'b0010011; words match the reference model seeded with 528; the shift-immediate masks hold.
3. **Backpressure:** `mode` = 1 with `out_ready` toggling 1,0,0,1 → `out_instr` is unchanged across the stalled cycles and `count` advances only on accepts. Every R-type word with funct3 ∉ {0, 5} has funct7 = 0.
4. **Hazard injection:**
   - Stimulus: `hazard_en` = 1, `HIST_DEPTH` = 2, 200 instructions.
   - Required: every instruction whose LFSR state had r[33:32] == 2'b11 has rs1 equal to `hist[r[34]]` per the model. About 25% of instructions are substituted.
5. **Restart and NOP mode:** after DONE, set `mode` = 3, `num_instr` = 3 and pulse `start` → three accepted words are all 32'h00000013, `count` restarts from 0, and the LFSR continues from the prior run's state.
6. **Zero seed and mid-run reset:** `SEED` = 0 with unlimited mode → the first word is derived from LFSR state 64'd1. Asserting `reset_n` = 0 mid-stall returns the block to the reset values on the next edge.
